uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised serial receiver; successor to the fixed-mode receiver in the serial link path.
- Samples an asynchronous RX line and decodes frames with runtime-selectable baud, word length (5–8), parity (none/even/odd) and stop bits (1/2).
- Pushes each decoded word with its error flags into an output FIFO, drained by a valid/ready handshake toward memory/CRC logic.
- Drives RTS flow control from FIFO occupancy.

Parameters:
- DIV0, 10416, clocks per bit for Baud_sel=0
- DIV1, 5208, clocks per bit for Baud_sel=1
- DIV2, 2604, clocks per bit for Baud_sel=2
- DIV3, 868, clocks per bit for Baud_sel=3
- CNT_W, 16, bit-timer width; must hold max(DIVn)
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- DATA_IN  in  1  serial RX line, idle high, asynchronous to Clock
- Baud_sel  in  2  DIV0..DIV3 select
- Data_bits  in  2  word length: 0=5, 1=6, 2=7, 3=8 bits
- Parity_en  in  1  parity bit present
- Parity_odd  in  1  1=odd, 0=even parity
- Two_stop  in  1  1=two stop bits
- DATA_OUT  out  8  head word, LSB-aligned, unused upper bits 0
- Parity_err  out  1  head-entry parity error
- Frame_err  out  1  head-entry stop-bit error
- Out_valid  out  1  FIFO non-empty
- Out_ready  in  1  consumer accepts head when Out_valid & Out_ready
- Overrun  out  1  sticky; a frame was dropped because FIFO was full
- Clr_overrun  in  1  synchronous clear of Overrun
- RTS  out  1  high when FIFO count < FIFO_DEPTH-1

Behaviour:
- Reset (async, any state): FSM=IDLE, timer=0, FIFO empty. DATA_OUT=0, Parity_err=0, Frame_err=0, Out_valid=0, Overrun=0, RTS=1.
- DATA_IN passes a 2-FF synchroniser and is then called rxs. All decoding uses rxs (2-cycle input latency).
- Config (Baud_sel, Data_bits, Parity_en, Parity_odd, Two_stop) is latched on the IDLE→START transition. Changes mid-frame do not affect that frame.
- Timer: loads and counts per state. A "tick" occurs when the timer reaches the latched DIV-1; the timer then reloads 0.
- FSM states:
  - IDLE: on rxs=0 → START with timer=0.
  - START: at half-bit (timer = DIV/2 - 1), if rxs=0 → DATA with timer=0. If rxs=1, treat as a glitch → IDLE; nothing is written.
  - DATA: sample rxs on each tick (bit centre). Data is LSB-first into shift register. Bit count runs 0..N-1. After bit N-1 → PARITY if Parity_en, else STOP1.
  - PARITY: on tick, sample p. Error if (XOR of data bits ^ p ^ Parity_odd) ≠ 0. → STOP1.
  - STOP1: on tick, rxs=0 sets frame error. → STOP2 if Two_stop, else COMMIT.
  - STOP2: on tick, rxs=0 sets frame error. → COMMIT.
  - COMMIT: one cycle. Write {frame_err, parity_err, word} to the FIFO if not full; if full, drop the frame and set Overrun. → IDLE.
- A frame error does not stop reception. If the line is still low in IDLE, a new START begins.
- FIFO:
  - Show-ahead: DATA_OUT, Parity_err and Frame_err reflect the head combinationally from registered storage.
  - Pop on Out_valid & Out_ready.
  - Simultaneous push and pop when full: the pop frees the slot, so the push succeeds and there is no overrun.
  - Pointers wrap modulo FIFO_DEPTH, with an extra count bit to distinguish full from empty.
- Overrun: set has priority over Clr_overrun in the same cycle.
- RTS: registered from the next-state count, so it updates the cycle after push/pop.
- Arithmetic: timer compare uses unsigned CNT_W widths. Half-bit value = DIVn >> 1.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT), data-bits encoding, default divisor constants. The transmitter will reuse this package.
- One sub-module: sync_fifo (parametrised width/depth, show-ahead, full/empty/count), instantiated with width 10.

Test Plan:
- DIV0 forced to 16 in the bench. 8N1 frame 0xA5 → one entry: DATA_OUT=0xA5, both errors 0, Out_valid high ~10 bit-times plus 3 cycles after the start edge.
- 7E1 with 0x35 (4 ones), parity bit 0 → DATA_OUT=0x35, Parity_err=0. Repeat with parity bit 1 → Parity_err=1.
- 5O2 with 0x1F, stop2 driven low → DATA_OUT=0x1F, Frame_err=1, Parity_err=0.
- Start glitch: low pulse of 4 cycles (< DIV/2) → FSM returns to IDLE, Out_valid stays 0.
- Out_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4:
  - RTS falls after the 3rd push.
  - 5th frame dropped, Overrun=1.
  - Draining returns 0x01..0x04 in order.
  - Clr_overrun clears Overrun.
- Reset asserted mid-DATA of frame 0x55 → outputs at reset values immediately. After release, a clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   uart_state_e  - frame FSM state encoding
//   data_bits_e   - word-length select encoding (5..8 bits)
//   DIVn_DEFAULT  - default clocks-per-bit divisors
//   last_bit_idx  - index of the final data bit for a word-length select
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        COMMIT
    } uart_state_e;

    typedef enum logic [1:0] {
        DB_5,
        DB_6,
        DB_7,
        DB_8
    } data_bits_e;

    localparam int DIV0_DEFAULT = 10416;
    localparam int DIV1_DEFAULT = 5208;
    localparam int DIV2_DEFAULT = 2604;
    localparam int DIV3_DEFAULT = 868;

    // 5 bits -> index 4, ..., 8 bits -> index 7
    function automatic logic [2:0] last_bit_idx(input data_bits_e db);
        return 3'(db) + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-word stream from the UART receiver to its consumer.
//   DATA_OUT   - head word, LSB-aligned
//   Parity_err - head-entry parity error
//   Frame_err  - head-entry stop-bit error
//   Out_valid  - a word is available
//   Out_ready  - consumer takes the head when Out_valid & Out_ready
interface uart_rx_param_if;
    logic [7:0] DATA_OUT;
    logic       Parity_err;
    logic       Frame_err;
    logic       Out_valid;
    logic       Out_ready;

    modport master (output DATA_OUT, Parity_err, Frame_err, Out_valid,
                    input  Out_ready);
    modport slave  (input  DATA_OUT, Parity_err, Frame_err, Out_valid,
                    output Out_ready);
endinterface

// File: rtl/uart_rx_param_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst   - clock, async active-high reset
//   push/wdata - write request and data (accepted if not full, or if popping)
//   pop        - remove head (ignored when empty)
//   rdata      - head entry, zero when empty
//   full/empty - occupancy flags
//   count_next - occupancy after this cycle's push/pop
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign rdata      = empty ? '0 : mem_q[rd_ptr_q];
    assign count_next = count_d;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: runtime-configurable UART receiver with output FIFO and RTS.
//   Clock, Reset   - system clock, async active-high reset
//   DATA_IN        - async serial line, idle high
//   Baud_sel, Data_bits, Parity_en, Parity_odd, Two_stop - frame config,
//                    captured when a start edge is seen
//   out_if         - decoded-word stream (show-ahead FIFO head)
//   Overrun        - sticky, a frame was dropped on a full FIFO
//   Clr_overrun    - clears Overrun (a new overrun wins)
//   RTS            - high while FIFO holds fewer than FIFO_DEPTH-1 words
//
// state  | meaning
// IDLE   | waiting for rxs low
// START  | confirming start bit at half-bit
// DATA   | sampling data bits at bit centres
// PARITY | sampling parity bit
// STOP1  | sampling first stop bit
// STOP2  | sampling second stop bit
// COMMIT | writing word + flags into the FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DIV0       = DIV0_DEFAULT,
    parameter int DIV1       = DIV1_DEFAULT,
    parameter int DIV2       = DIV2_DEFAULT,
    parameter int DIV3       = DIV3_DEFAULT,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   DATA_IN,
    input  logic [1:0]             Baud_sel,
    input  logic [1:0]             Data_bits,
    input  logic                   Parity_en,
    input  logic                   Parity_odd,
    input  logic                   Two_stop,
    uart_rx_param_if.master        out_if,
    output logic                   Overrun,
    input  logic                   Clr_overrun,
    output logic                   RTS
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic              sync1_q, sync2_q, rxs;
    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  div_q, div_d, div_sel;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        last_q, last_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              perr_q, perr_d, ferr_q, ferr_d;
    logic              pen_q, pen_d, podd_q, podd_d, two_q, two_d;
    logic              overrun_q, overrun_d;
    logic              rts_q;
    logic              tick, half_hit, push, pop, full, empty;
    logic [AW:0]       count_next;

    assign rxs      = sync2_q;
    assign tick     = (timer_q == (div_q - CNT_W'(1)));
    assign half_hit = (timer_q == ((div_q >> 1) - CNT_W'(1)));

    always_comb begin
        case (Baud_sel)
            2'd0:    div_sel = CNT_W'(DIV0);
            2'd1:    div_sel = CNT_W'(DIV1);
            2'd2:    div_sel = CNT_W'(DIV2);
            default: div_sel = CNT_W'(DIV3);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        pen_d     = pen_q;
        podd_d    = podd_q;
        two_d     = two_q;
        push      = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs) begin
                    state_d   = START;
                    div_d     = div_sel;
                    last_d    = last_bit_idx(data_bits_e'(Data_bits));
                    pen_d     = Parity_en;
                    podd_d    = Parity_odd;
                    two_d     = Two_stop;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            START: begin
                if (half_hit) begin
                    timer_d = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d            = '0;
                    shreg_d[bit_cnt_q] = rxs;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_q) state_d = pen_q ? PARITY : STOP1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    timer_d = '0;
                    perr_d  = (^shreg_q) ^ rxs ^ podd_q;
                    state_d = STOP1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            STOP1: begin
                if (tick) begin
                    timer_d = '0;
                    if (!rxs) ferr_d = 1'b1;
                    state_d = two_q ? STOP2 : COMMIT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            STOP2: begin
                if (tick) begin
                    timer_d = '0;
                    if (!rxs) ferr_d = 1'b1;
                    state_d = COMMIT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                push    = 1'b1;
                timer_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign pop = ~empty & out_if.Out_ready;

    always_comb begin
        overrun_d = overrun_q;
        if (Clr_overrun) overrun_d = 1'b0;
        if (push && full && !pop) overrun_d = 1'b1;
    end

    sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (Clock),
        .rst        (Reset),
        .push       (push),
        .wdata      ({ferr_q, perr_q, shreg_q}),
        .pop        (pop),
        .rdata      ({out_if.Frame_err, out_if.Parity_err, out_if.DATA_OUT}),
        .full       (full),
        .empty      (empty),
        .count_next (count_next)
    );

    assign out_if.Out_valid = ~empty;
    assign Overrun          = overrun_q;
    assign RTS              = rts_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            div_q     <= CNT_W'(DIV0);
            bit_cnt_q <= '0;
            last_q    <= 3'd7;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            two_q     <= 1'b0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            sync1_q   <= DATA_IN;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            pen_q     <= pen_d;
            podd_q    <= podd_d;
            two_q     <= two_d;
            overrun_q <= overrun_d;
            rts_q     <= (count_next < (AW+1)'(FIFO_DEPTH - 1));
        end
    end
endmodule
